// File: rtl/coeff_bank_pkg.sv
// Shared FSM type, address-map constants and counter width for the APB coefficient bank.
package coeff_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_ACK,
        ST_RD_WAIT,
        ST_RD_ACK
    } apb_state_e;

    localparam bit REGION_COEFF = 1'b0;
    localparam bit REGION_CTRL  = 1'b1;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_ERRCNT = 1;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/coeff_bank_store.sv
// One coefficient bank: tap storage, commit-pending bit and frame-synchronous shadow->active swap.
// Latency: writes land on the next edge; active and vld update together on the swap edge.
// Backpressure: none, all inputs are single-cycle strobes.
module coeff_bank_store
    import coeff_bank_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int COEFF_WIDTH = 20,
    parameter int TAP_W       = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [TAP_W-1:0]             wr_tap_i,
    input  logic [COEFF_WIDTH-1:0]       wr_dat_i,
    input  logic                         commit_i,
    input  logic                         frame_sync_i,
    input  logic [TAP_W-1:0]             rd_tap_i,
    output logic [COEFF_WIDTH-1:0]       rd_dat_o,
    output logic [DEPTH*COEFF_WIDTH-1:0] active_o,
    output logic                         pending_o,
    output logic                         vld_o
);

    logic [COEFF_WIDTH-1:0] active_q [DEPTH];
    logic                   vld_q;

`ifdef COEFF_BANK_DOUBLE_BUF_EN
    logic [COEFF_WIDTH-1:0] shadow_q [DEPTH];
    logic                   pending_q;
    logic                   pending_d;
    logic                   swap;

    assign swap      = frame_sync_i && pending_q;
    // A commit arriving on the swap edge re-arms the bank for the following frame.
    assign pending_d = (pending_q && !swap) || commit_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < DEPTH; t++) begin
                shadow_q[t] <= '0;
                active_q[t] <= '0;
            end
            pending_q <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            if (swap) active_q <= shadow_q;
            if (wr_en_i) shadow_q[wr_tap_i] <= wr_dat_i;
            pending_q <= pending_d;
            vld_q     <= swap;
        end
    end

    assign rd_dat_o  = shadow_q[rd_tap_i];
    assign pending_o = pending_q;
`else
    logic unused_ok;
    assign unused_ok = commit_i ^ frame_sync_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < DEPTH; t++) active_q[t] <= '0;
            vld_q <= 1'b0;
        end else begin
            if (wr_en_i) active_q[wr_tap_i] <= wr_dat_i;
            vld_q <= wr_en_i;
        end
    end

    assign rd_dat_o  = active_q[rd_tap_i];
    assign pending_o = 1'b0;
`endif

    for (genvar t = 0; t < DEPTH; t++) begin : g_tap
        assign active_o[t*COEFF_WIDTH +: COEFF_WIDTH] = active_q[t];
    end

    assign vld_o = vld_q;

endmodule

// File: rtl/apb_coeff_bank.sv
// APB3 slave over N_BANK coefficient banks; COEFF_BANK_DOUBLE_BUF_EN selects shadow/active with commit.
// Latency: writes ack with 0 wait states, reads with 1; PRDATA/PREADY/PSLVERR registered.
// Backpressure: only the fixed read wait state; frame_sync and coeff outputs are never stalled.
module apb_coeff_bank
    import coeff_bank_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int PDATA_WIDTH = 32,
    parameter int COEFF_WIDTH = 20,
    parameter int N_BANK      = 4,
    parameter int DEPTH       = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                PSEL,
    input  logic                                PENABLE,
    input  logic                                PWRITE,
    input  logic [ADDR_WIDTH-1:0]               PADDR,
    input  logic [PDATA_WIDTH-1:0]              PWDATA,
    output logic [PDATA_WIDTH-1:0]              PRDATA,
    output logic                                PREADY,
    output logic                                PSLVERR,
    input  logic                                frame_sync,
    output logic [N_BANK*DEPTH*COEFF_WIDTH-1:0] coeff_active,
    output logic [N_BANK-1:0]                   coeff_vld,
    output logic [ERR_CNT_W-1:0]                err_cnt
);

    localparam int IDX_W     = ADDR_WIDTH - 1;
    localparam int TAP_W     = $clog2(DEPTH);
    localparam int BANK_W    = (IDX_W > TAP_W) ? IDX_W - TAP_W : 1;
    localparam int N_ENT     = N_BANK * DEPTH;
    localparam int BANK_BITS = DEPTH * COEFF_WIDTH;

    apb_state_e             state_q;
    logic [PDATA_WIDTH-1:0] prdata_q;
    logic                   pready_q;
    logic                   pslverr_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [ERR_CNT_W-1:0]   err_cnt_d;

    logic [IDX_W-1:0]       idx;
    logic [TAP_W-1:0]       tap_sel;
    logic [BANK_W-1:0]      bank_sel;
    logic                   coeff_hit;
    logic                   commit_addr;
    logic                   commit_hit;
    logic                   errcnt_hit;
    logic                   addr_err;
    logic                   wr_fire;
    logic [COEFF_WIDTH-1:0] bank_rd [N_BANK];
    logic [COEFF_WIDTH-1:0] rd_coeff;
    logic [PDATA_WIDTH-1:0] rd_word;
    logic [N_BANK-1:0]      pend;

    assign idx         = PADDR[IDX_W-1:0];
    assign tap_sel     = idx[TAP_W-1:0];
    assign bank_sel    = BANK_W'(idx >> TAP_W);
    assign coeff_hit   = (PADDR[ADDR_WIDTH-1] == REGION_COEFF) && (32'(idx) < 32'(N_ENT));
    assign commit_addr = (PADDR[ADDR_WIDTH-1] == REGION_CTRL) && (idx == IDX_W'(CTRL_COMMIT));
    assign errcnt_hit  = (PADDR[ADDR_WIDTH-1] == REGION_CTRL) && (idx == IDX_W'(CTRL_ERRCNT));

`ifdef COEFF_BANK_DOUBLE_BUF_EN
    assign commit_hit = commit_addr;
`else
    // Without a shadow there is nothing to commit, so the offset decodes as unmapped.
    assign commit_hit = 1'b0;
`endif

    assign addr_err = !(coeff_hit || commit_hit || errcnt_hit);
    assign wr_fire  = (state_q == ST_WR_ACK) && !pslverr_q;

    always_comb begin
        rd_coeff = '0;
        for (int b = 0; b < N_BANK; b++) begin
            if (bank_sel == BANK_W'(b)) rd_coeff = bank_rd[b];
        end
    end

    always_comb begin
        rd_word = '0;
        if (coeff_hit)       rd_word = PDATA_WIDTH'(signed'(rd_coeff));
        else if (commit_hit) rd_word = PDATA_WIDTH'(pend);
        else if (errcnt_hit) rd_word = PDATA_WIDTH'(err_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        if (PWRITE) begin
                            state_q   <= ST_WR_ACK;
                            pready_q  <= 1'b1;
                            pslverr_q <= addr_err;
                        end else begin
                            state_q <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    state_q   <= ST_RD_ACK;
                    pready_q  <= 1'b1;
                    pslverr_q <= addr_err;
                    prdata_q  <= addr_err ? '0 : rd_word;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (wr_fire && errcnt_hit)
            err_cnt_d = '0;
        else if (pready_q && pslverr_q && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    for (genvar b = 0; b < N_BANK; b++) begin : g_bank
        coeff_bank_store #(
            .DEPTH       (DEPTH),
            .COEFF_WIDTH (COEFF_WIDTH),
            .TAP_W       (TAP_W)
        ) u_store (
            .clk          (clk),
            .rst          (rst),
            .wr_en_i      (wr_fire && coeff_hit && (bank_sel == BANK_W'(b))),
            .wr_tap_i     (tap_sel),
            .wr_dat_i     (PWDATA[COEFF_WIDTH-1:0]),
            .commit_i     (wr_fire && commit_hit && PWDATA[b]),
            .frame_sync_i (frame_sync),
            .rd_tap_i     (tap_sel),
            .rd_dat_o     (bank_rd[b]),
            .active_o     (coeff_active[b*BANK_BITS +: BANK_BITS]),
            .pending_o    (pend[b]),
            .vld_o        (coeff_vld[b])
        );
    end

    logic unused_ok;
    assign unused_ok = ^{PWDATA, commit_addr};

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_coeff_bank.sv
// Randomized APB traffic against a behavioural bank model; three banks leave part of the coeff region unmapped.
module tb_apb_coeff_bank;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int CW   = 20;
    localparam int NB   = 3;
    localparam int DEP  = 32;
    localparam int NENT = NB * DEP;
    localparam int BB   = DEP * CW;
`ifdef COEFF_BANK_DOUBLE_BUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           PSEL = 1'b0;
    logic           PENABLE = 1'b0;
    logic           PWRITE = 1'b0;
    logic           frame_sync = 1'b0;
    logic [AW-1:0]  PADDR = '0;
    logic [DW-1:0]  PWDATA = '0;
    logic [DW-1:0]  PRDATA;
    logic           PREADY;
    logic           PSLVERR;
    logic [NB*BB-1:0] coeff_active;
    logic [NB-1:0]  coeff_vld;
    logic [7:0]     err_cnt;

    always #5 clk = ~clk;

    apb_coeff_bank #(
        .ADDR_WIDTH (AW),
        .PDATA_WIDTH(DW),
        .COEFF_WIDTH(CW),
        .N_BANK     (NB),
        .DEPTH      (DEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .frame_sync  (frame_sync),
        .coeff_active(coeff_active),
        .coeff_vld   (coeff_vld),
        .err_cnt     (err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0] m_shadow [NENT];
    logic [CW-1:0] m_active [NENT];
    logic [NB-1:0] m_pend;
    int            m_err;

    task automatic chk(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_pend = '0;
        m_err  = 0;
    endtask

    function automatic bit exp_err(input logic [AW-1:0] a);
        if (!a[AW-1]) return int'(a[AW-2:0]) >= NENT;
        if (a[AW-2:0] == 0) return !DBUF;
        if (a[AW-2:0] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic [CW-1:0] v;
        if (exp_err(a)) return '0;
        if (!a[AW-1]) begin
            v = DBUF ? m_shadow[int'(a[AW-2:0])] : m_active[int'(a[AW-2:0])];
            return {{(DW-CW){v[CW-1]}}, v};
        end
        if (a[AW-2:0] == 0) return DW'(m_pend);
        return DW'(m_err);
    endfunction

    function automatic logic [BB-1:0] bank_vec(input int b);
        logic [BB-1:0] v;
        for (int t = 0; t < DEP; t++) v[t*CW +: CW] = m_active[b*DEP + t];
        return v;
    endfunction

    task automatic check_active();
        for (int b = 0; b < NB; b++)
            chk($sformatf("active_bank%0d", b), coeff_active[b*BB +: BB], bank_vec(b));
    endtask

    task automatic err_bump();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_swap(output logic [NB-1:0] sw);
        sw = DBUF ? m_pend : '0;
        for (int b = 0; b < NB; b++)
            if (sw[b])
                for (int t = 0; t < DEP; t++) m_active[b*DEP + t] = m_shadow[b*DEP + t];
        m_pend = m_pend & ~sw;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit fs,
                               output logic [NB-1:0] vld);
        logic [NB-1:0] sw;
        int i;
        sw = '0;
        if (fs) model_swap(sw);
        vld = sw;
        i = int'(a[AW-2:0]);
        if (exp_err(a)) err_bump();
        else if (!a[AW-1]) begin
            if (DBUF) m_shadow[i] = d[CW-1:0];
            else begin
                m_active[i] = d[CW-1:0];
                vld[i / DEP] = 1'b1;
            end
        end
        else if (a[AW-2:0] == 0) m_pend = m_pend | d[NB-1:0];
        else m_err = 0;
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit fs);
        logic          e;
        logic [NB-1:0] vld;
        e = exp_err(a);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge clk);
        PENABLE = 1'b1; frame_sync = fs;
        chk("wr_pready", PREADY, 1'b1);
        chk("wr_pslverr", PSLVERR, e);
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; frame_sync = 1'b0;
        model_write(a, d, fs, vld);
        chk("wr_end_pready", PREADY, 1'b0);
        chk("wr_vld", coeff_vld, vld);
        chk("wr_errcnt", err_cnt, m_err[7:0]);
        check_active();
    endtask

    task automatic apb_read(input logic [AW-1:0] a);
        logic          e;
        logic [DW-1:0] r;
        e = exp_err(a);
        r = exp_rd(a);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge clk);
        PENABLE = 1'b1;
        chk("rd_wait_pready", PREADY, 1'b0);
        @(negedge clk);
        chk("rd_pready", PREADY, 1'b1);
        chk("rd_pslverr", PSLVERR, e);
        chk("rd_prdata", PRDATA, r);
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("rd_end_pready", PREADY, 1'b0);
        chk("rd_end_prdata", PRDATA, '0);
        if (e) err_bump();
        chk("rd_errcnt", err_cnt, m_err[7:0]);
    endtask

    task automatic pulse_frame();
        logic [NB-1:0] sw;
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        model_swap(sw);
        chk("fs_vld", coeff_vld, sw);
        check_active();
        @(negedge clk);
        chk("fs_vld_clear", coeff_vld, '0);
    endtask

    initial begin
        int op;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_prdata", PRDATA, '0);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        chk("rst_vld", coeff_vld, '0);
        chk("rst_errcnt", err_cnt, '0);
        check_active();
        rst = 1'b0;

        // Sign-extended readback with one wait state.
        apb_write(8'h03, 32'h000F_FFFF, 1'b0);
        apb_read(8'h03);

        // Staged bank-2 update, then frame boundary.
        apb_write(8'h40, 32'h0000_0123, 1'b0);
        apb_write(8'h80, 32'h0000_0004, 1'b0);
        pulse_frame();
        chk("bank2_tap0", coeff_active[2*BB +: CW], 20'h00123);

        // Commit on the same edge as frame_sync waits for the next boundary.
        apb_write(8'h41, 32'h0008_0005, 1'b0);
        apb_write(8'h80, 32'h0000_0004, 1'b1);
        pulse_frame();
        apb_read(8'h80);

        // Unmapped coeff index and unmapped control offset, then clear.
        apb_read(8'h7F);
        apb_read(8'h85);
        apb_read(8'h81);
        apb_write(8'h81, 32'h0, 1'b0);
        apb_read(8'h81);

        repeat (260) apb_write(8'h85, $urandom, 1'b0);
        chk("err_sat", err_cnt, 8'd255);
        apb_write(8'h81, 32'h0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: apb_write(8'($urandom_range(0, 127)), $urandom, 1'b0);
                3, 4:    apb_read(8'($urandom_range(0, 255)));
                5:       apb_write(8'h80, 32'($urandom_range(0, 7)), 1'b0);
                6:       pulse_frame();
                7:       apb_write(8'($urandom_range(0, 127)), $urandom, 1'b1);
                8:       apb_write(8'h80, 32'($urandom_range(0, 7)), 1'b1);
                default: apb_write(8'($urandom_range(128, 135)), $urandom, 1'b0);
            endcase
        end

        // Populate state, then reset in the middle of a read.
        apb_write(8'h03, 32'h000A_BCDE, 1'b0);
        apb_write(8'h80, 32'h0000_0001, 1'b0);
        pulse_frame();
        apb_write(8'h86, 32'h0, 1'b0);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h03;
        @(negedge clk);
        PENABLE = 1'b1; rst = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
        model_reset();
        chk("midrst_pready", PREADY, 1'b0);
        chk("midrst_pslverr", PSLVERR, 1'b0);
        chk("midrst_prdata", PRDATA, '0);
        chk("midrst_vld", coeff_vld, '0);
        chk("midrst_errcnt", err_cnt, '0);
        check_active();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_pready_after", PREADY, 1'b0);
        apb_read(8'h03);
        apb_read(8'h80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
